// File: rtl/boot_loader_pkg.sv
// Shared widths, write-enable codes and state encodings for the boot copy block.
package boot_loader_pkg;

    localparam int XLEN   = 32;
    localparam int AWIDTH = 12;

    localparam logic [2:0]      WE_NONE  = 3'b000;
    localparam logic [2:0]      WE_WORD  = 3'b110;
    localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

    localparam logic [1:0] BL_FETCH = 2'd0;
    localparam logic [1:0] BL_WRITE = 2'd1;
    localparam logic [1:0] BL_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_FETCH = BL_FETCH,
        S_WRITE = BL_WRITE,
        S_DONE  = BL_DONE
    } bl_state_e;

    // Copy window must be whole words, non-empty and fit inside the ROM.
    function automatic bit copy_cfg_ok(input int src_base, input int copy_bytes);
        return (copy_bytes > 0) && (copy_bytes % 4 == 0) && (src_base >= 0) &&
               (src_base + copy_bytes <= (1 << AWIDTH));
    endfunction

endpackage

// File: rtl/boot_loader_copy_fsm.sv
// Sequencer for the ROM-to-RAM start-up copy: state, byte offset and
// (when BOOT_CHECKSUM_EN is defined) the running sum of copied words.
//
//   state   | meaning
//   S_FETCH | ROM address for the next word is presented
//   S_WRITE | ROM word from last cycle is written to RAM, offset advances
//   S_DONE  | copy finished, memory ports handed to the core (absorbing)
module boot_copy_fsm
    import boot_loader_pkg::*;
#(
    parameter int SRC_BASE   = 'h800,
    parameter int COPY_BYTES = 'h800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   rom_data,
    output logic [AWIDTH-1:0] fetch_addr_o,
    output logic [AWIDTH-1:0] wr_addr_o,
    output logic              wr_en_o,
    output logic              done_o
`ifdef BOOT_CHECKSUM_EN
    ,
    output logic [XLEN-1:0]   checksum_o
`endif
);

    // One extra bit so the offset cannot wrap before the last-word compare.
    localparam logic [AWIDTH:0]   LAST_OFF = (AWIDTH+1)'(COPY_BYTES - 4);
    localparam logic [AWIDTH-1:0] SRC_OFF  = AWIDTH'(SRC_BASE);

    bl_state_e       state_q, state_d;
    logic [AWIDTH:0] offset_q, offset_d;

    // State and offset registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
        end
    end

    // Next state: alternate fetch/write until the last word has been written.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        case (state_q)
            S_FETCH: state_d = S_WRITE;
            S_WRITE: begin
                offset_d = offset_q + (AWIDTH+1)'(4);
                state_d  = (offset_q == LAST_OFF) ? S_DONE : S_FETCH;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_FETCH;
        endcase
    end

    // Output decodes of the registered state.
    always_comb begin
        fetch_addr_o = SRC_OFF + offset_q[AWIDTH-1:0];
        wr_addr_o    = offset_q[AWIDTH-1:0];
        wr_en_o      = (state_q == S_WRITE);
        done_o       = (state_q == S_DONE);
    end

`ifdef BOOT_CHECKSUM_EN
    logic [XLEN-1:0] checksum_q;

    // Sum of every word written; holds once the copy is done.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (state_q == S_WRITE) begin
            checksum_q <= checksum_q + rom_data;
        end
    end

    assign checksum_o = checksum_q;
`endif

endmodule

// File: rtl/boot_loader.sv
// Start-up copy engine between the core and its ROM/RAM. Holds the core while
// the data image is copied, then becomes a zero-latency pass-through.
// Optional output boot_checksum is present when BOOT_CHECKSUM_EN is defined.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int SRC_BASE   = 'h800,
    parameter int COPY_BYTES = 'h800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] core_inst_addr,
    output logic [XLEN-1:0]   core_inst_data,
    output logic [AWIDTH-1:0] rom_addr,
    input  logic [XLEN-1:0]   rom_data,
    input  logic [AWIDTH-1:0] core_dmem_addr,
    input  logic [XLEN-1:0]   core_dmem_wdata,
    input  logic [2:0]        core_dmem_we,
    output logic [XLEN-1:0]   core_dmem_rdata,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [XLEN-1:0]   ram_wdata,
    output logic [2:0]        ram_we,
    input  logic [XLEN-1:0]   ram_rdata,
    output logic              core_hold,
    output logic              boot_done
`ifdef BOOT_CHECKSUM_EN
    ,
    output logic [XLEN-1:0]   boot_checksum
`endif
);

    if (!copy_cfg_ok(SRC_BASE, COPY_BYTES)) begin : g_bad_copy_cfg
        $error("boot_loader: COPY_BYTES must be a positive multiple of 4 with SRC_BASE+COPY_BYTES <= 2**AWIDTH");
    end

    logic [AWIDTH-1:0] fetch_addr;
    logic [AWIDTH-1:0] wr_addr;
    logic              wr_en;
    logic              done;

    boot_copy_fsm #(
        .SRC_BASE   (SRC_BASE),
        .COPY_BYTES (COPY_BYTES)
    ) u_copy_fsm (
        .clk          (clk),
        .rst          (rst),
        .rom_data     (rom_data),
        .fetch_addr_o (fetch_addr),
        .wr_addr_o    (wr_addr),
        .wr_en_o      (wr_en),
        .done_o       (done)
`ifdef BOOT_CHECKSUM_EN
        ,
        .checksum_o   (boot_checksum)
`endif
    );

    // Port ownership: copy engine during boot, core afterwards. Core dmem
    // inputs are ignored until done, and no write leaves while rst is high.
    always_comb begin
        rom_addr        = done ? core_inst_addr  : fetch_addr;
        core_inst_data  = done ? rom_data        : NOP_INST;
        ram_addr        = done ? core_dmem_addr  : wr_addr;
        ram_wdata       = done ? core_dmem_wdata : rom_data;
        ram_we          = done ? core_dmem_we    : (wr_en ? WE_WORD : WE_NONE);
        core_dmem_rdata = done ? ram_rdata       : '0;
        if (rst) begin
            ram_we = WE_NONE;
        end
    end

    assign core_hold = ~done;
    assign boot_done = done;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: ROM/RAM models, expected-write scoreboard checked by a
// monitor, randomised core traffic during and after boot.
module tb_boot_loader;

    localparam int SRC      = 'h800;
    localparam int NB       = 'h800;
    localparam int NW       = NB / 4;
    localparam int BOOT_CYC = 2 * NW;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] core_inst_addr;
    logic [31:0] core_inst_data;
    logic [11:0] rom_addr;
    logic [31:0] rom_data;
    logic [11:0] core_dmem_addr;
    logic [31:0] core_dmem_wdata;
    logic [2:0]  core_dmem_we;
    logic [31:0] core_dmem_rdata;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [2:0]  ram_we;
    logic [31:0] ram_rdata;
    logic        core_hold;
    logic        boot_done;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] boot_checksum;
`endif

    logic [31:0] rom_mem [0:1023];
    logic [31:0] ram_mem [0:1023];
    logic [31:0] ram_ref [0:NW-1];

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    boot_loader #(.SRC_BASE(SRC), .COPY_BYTES(NB)) dut (
        .clk             (clk),
        .rst             (rst),
        .core_inst_addr  (core_inst_addr),
        .core_inst_data  (core_inst_data),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .core_dmem_addr  (core_dmem_addr),
        .core_dmem_wdata (core_dmem_wdata),
        .core_dmem_we    (core_dmem_we),
        .core_dmem_rdata (core_dmem_rdata),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_we          (ram_we),
        .ram_rdata       (ram_rdata),
        .core_hold       (core_hold),
        .boot_done       (boot_done)
`ifdef BOOT_CHECKSUM_EN
        ,
        .boot_checksum   (boot_checksum)
`endif
    );

    always @(posedge clk) rom_data <= rom_mem[rom_addr[11:2]];
    always @(posedge clk) if (ram_we == 3'b110) ram_mem[ram_addr[11:2]] <= ram_wdata;
    assign ram_rdata = ram_mem[ram_addr[11:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a full copy is the image words in order, to RAM from byte 0.
    task automatic push_copy();
        for (int n = 0; n < NW; n++)
            exp_q.push_back('{addr: 12'(4 * n), data: rom_mem[SRC / 4 + n]});
    endtask

    function automatic logic [31:0] image_sum();
        logic [31:0] s = '0;
        for (int n = 0; n < NW; n++) s += rom_mem[SRC / 4 + n];
        return s;
    endfunction

    // Monitor: every RAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            chk("we_gated_in_reset", 32'(ram_we), 32'd0);
        end else if (ram_we != 3'b000) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ram_write: got addr %h data %h we %b expected no write",
                         ram_addr, ram_wdata, ram_we);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(mon_e.addr));
                chk("wr_data", ram_wdata, mon_e.data);
                chk("wr_we", 32'(ram_we), 32'(3'b110));
            end
        end
    end

    task automatic idle_core();
        core_inst_addr  = '0;
        core_dmem_addr  = '0;
        core_dmem_wdata = '0;
        core_dmem_we    = 3'b000;
    endtask

    task automatic drive_random_core(input int cyc);
        core_inst_addr = (cyc % 3 == 0) ? 12'(4 * $urandom_range(0, 1023)) : 12'h000;
        if (cyc % 8 == 0) begin
            core_dmem_addr  = 12'h010;
            core_dmem_wdata = 32'hDEADBEEF;
            core_dmem_we    = 3'b110;
        end else begin
            core_dmem_addr  = 12'($urandom);
            core_dmem_wdata = $urandom;
            core_dmem_we    = ($urandom_range(0, 1) == 1) ? 3'b110 : 3'($urandom);
        end
    endtask

    // Reset, release, optionally pulse rst once mid-copy, then time boot_done.
    task automatic run_boot(input int rst_at);
        int cyc;
        bit restarted;
        idle_core();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        push_copy();
        chk("reset_core_hold", 32'(core_hold), 32'd1);
        chk("reset_boot_done", 32'(boot_done), 32'd0);
        chk("reset_ram_we", 32'(ram_we), 32'd0);
        cyc = 0;
        restarted = 1'b0;
        while (cyc < 4 * BOOT_CYC) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!restarted && cyc == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("midreset_core_hold", 32'(core_hold), 32'd1);
                @(posedge clk);
                #1;
                rst = 1'b0;
                exp_q.delete();
                push_copy();
                chk("midreset_boot_done", 32'(boot_done), 32'd0);
                cyc = 0;
                restarted = 1'b1;
                continue;
            end
            if (boot_done) idle_core();
            else drive_random_core(cyc);
            @(negedge clk);
            if (boot_done) break;
            chk("boot_core_hold", 32'(core_hold), 32'd1);
            chk("boot_inst_nop", core_inst_data, NOP);
            chk("boot_dmem_rdata_zero", core_dmem_rdata, 32'd0);
        end
        chk("boot_latency", 32'(cyc), 32'(BOOT_CYC));
        chk("copy_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_image();
        int bad = 0;
        for (int n = 0; n < NW; n++) begin
            ram_ref[n] = rom_mem[SRC / 4 + n];
            if (ram_mem[n] !== ram_ref[n]) bad++;
        end
        chk("ram_image_bad_words", 32'(bad), 32'd0);
        chk("ram_10_is_copied_word", ram_mem[4], rom_mem[SRC / 4 + 4]);
    endtask

    task automatic dmem_write(input logic [11:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        core_dmem_addr  = a;
        core_dmem_wdata = d;
        core_dmem_we    = 3'b110;
        exp_q.push_back('{addr: a, data: d});
        ram_ref[a[10:2]] = d;
        @(negedge clk);
        chk("done_same_cycle_we", 32'(ram_we), 32'(3'b110));
    endtask

    task automatic dmem_read(input logic [11:0] a);
        @(posedge clk);
        #1;
        core_dmem_addr = a;
        core_dmem_we   = 3'b000;
        @(negedge clk);
        chk("done_dmem_readback", core_dmem_rdata, ram_ref[a[10:2]]);
    endtask

    task automatic post_boot_checks();
        logic [11:0] a;
        logic [11:0] prev;
        dmem_write(12'h020, 32'h12345678);
        dmem_read(12'h020);
        chk("readback_20", core_dmem_rdata, 32'h12345678);
        for (int i = 0; i < 12; i++) begin
            a = 12'(4 * $urandom_range(0, NW - 1));
            dmem_write(a, $urandom);
            dmem_read(a);
        end
        idle_core();
        @(posedge clk);
        #1;
        core_inst_addr = 12'h008;
        @(posedge clk);
        #1;
        core_inst_addr = 12'h004;
        @(negedge clk);
        chk("inst_prev_word_same_cycle", core_inst_data, rom_mem[2]);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("inst_word_4_next_cycle", core_inst_data, rom_mem[1]);
        prev = core_inst_addr;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            core_inst_addr = 12'(4 * $urandom_range(0, 1023));
            @(negedge clk);
            chk("inst_rand_latency", core_inst_data, rom_mem[prev[11:2]]);
            prev = core_inst_addr;
        end
        idle_core();
    endtask

    initial begin
        idle_core();
        for (int i = 0; i < 1024; i++) begin
            rom_mem[i] = 32'(4 * i) ^ 32'hA5A5A5A5;
            ram_mem[i] = '0;
        end
        run_boot(-1);
        check_image();

        for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
        // Restart mid-copy on a write cycle so the reset-cycle write gate matters.
        run_boot(301);
        check_image();
`ifdef BOOT_CHECKSUM_EN
        chk("checksum_after_midreset", boot_checksum, image_sum());
`endif
        post_boot_checks();

        for (int i = 0; i < 1024; i++) rom_mem[i] = 32'h00000001;
        run_boot(-1);
        check_image();
`ifdef BOOT_CHECKSUM_EN
        chk("checksum_ones", boot_checksum, 32'h00000200);
        chk("checksum_model", boot_checksum, image_sum());
        repeat (5) @(posedge clk);
        #1;
        chk("checksum_frozen", boot_checksum, 32'h00000200);
`endif
        @(negedge clk);
        chk("final_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
